// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mult_pkg;

    localparam int unsigned MULT_W    = 32;
    localparam int unsigned MULT_ITER = 32;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SIGN = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_if.sv
// Controller <-> multiplier signal bundle: start/operands, MTHI/MTLO writes, status and HI/LO.
interface mult_if;

    logic        startmult;
    logic        multsign;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output startmult, multsign, srca, srcb, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  startmult, multsign, srca, srcb, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_absval.sv
// Operand magnitude and sign; |0x80000000| wraps to 0x80000000, which is correct read as unsigned.
module mult_absval (
    input  logic [31:0] operand,
    input  logic        multsign,
    output logic [31:0] mag,
    output logic        neg
);

    always_comb begin
        neg = multsign & operand[31];
        mag = neg ? (~operand + 32'd1) : operand;
    end

endmodule

// File: rtl/mult_unit.sv
// Iterative 32x32 shift-add multiplier with HI/LO registers (MTHI/MTLO writable in IDLE).
// Optional macro MULT_EARLY_TERM_EN ends BUSY once the remaining multiplier is zero.
module mult_unit
    import mult_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    mult_if.slave  bus
);

    mult_state_t           state;
    logic [2*MULT_W-1:0]   mcand;
    logic [2*MULT_W-1:0]   acc;
    logic [MULT_W-1:0]     mplier;
    logic [CNT_W-1:0]      count;
    logic                  res_neg;
    logic [MULT_W-1:0]     hi_r;
    logic [MULT_W-1:0]     lo_r;
    logic                  done_r;

    logic [MULT_W-1:0]     mag_a;
    logic [MULT_W-1:0]     mag_b;
    logic                  neg_a;
    logic                  neg_b;

    logic [2*MULT_W-1:0]   acc_next;
    logic [MULT_W-1:0]     mplier_next;
    logic [2*MULT_W-1:0]   result;
    logic                  last_step;

    mult_absval u_abs_a (
        .operand  (bus.srca),
        .multsign (bus.multsign),
        .mag      (mag_a),
        .neg      (neg_a)
    );

    mult_absval u_abs_b (
        .operand  (bus.srcb),
        .multsign (bus.multsign),
        .mag      (mag_b),
        .neg      (neg_b)
    );

    always_comb begin
        acc_next    = acc + (mplier[0] ? mcand : '0);
        mplier_next = mplier >> 1;
        result      = res_neg ? (~acc + 64'd1) : acc;
`ifdef MULT_EARLY_TERM_EN
        last_step   = (mplier_next == '0) || (count == CNT_W'(MULT_ITER - 1));
`else
        last_step   = (count == CNT_W'(MULT_ITER - 1));
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            count   <= '0;
            res_neg <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // MTHI/MTLO and a start in the same cycle both act; the product overwrites later.
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.startmult) begin
                        mcand   <= {{MULT_W{1'b0}}, mag_a};
                        mplier  <= mag_b;
                        acc     <= '0;
                        count   <= '0;
                        res_neg <= neg_a ^ neg_b;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + CNT_W'(1);
                    if (last_step) state <= SIGN;
                end
                SIGN: begin
                    {hi_r, lo_r} <= result;
                    done_r       <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule
